// File: rtl/fetch_queue.sv
// Instruction fetch stage: credit-gated sequential fetch into a small prefetch FIFO.
// The instruction memory has a one-cycle read latency; a redirect flushes everything.
module fetch_queue #(
   parameter int                DWIDTH   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [DWIDTH-1:0] redirect_pc,
   output logic              imem_req,
   output logic [DWIDTH-1:0] imem_addr,
   input  logic [DWIDTH-1:0] imem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_pc,
   output logic [DWIDTH-1:0] out_instr
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0]     PTR_ONE = PW'(1);
   localparam logic [CW-1:0]     CNT_ONE = CW'(1);
   localparam logic [CW:0]       DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

   logic [DWIDTH-1:0] fetch_pc;
   logic              inflight;
   logic [DWIDTH-1:0] inflight_pc;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic [DWIDTH-1:0] hold_pc;
   logic [DWIDTH-1:0] hold_instr;
   logic              push;
   logic              pop;

   logic [DWIDTH-1:0] pc_mem    [DEPTH];
   logic [DWIDTH-1:0] instr_mem [DEPTH];

   // Buffered entries plus the fetch still in flight must stay below DEPTH;
   // the same-cycle pop is deliberately ignored to keep the path short.
   function automatic logic has_credit(input logic [CW-1:0] cnt, input logic inf);
      logic [CW:0] used;
      used = {1'b0, cnt} + {{CW{1'b0}}, inf};
      return used < DEPTH_C;
   endfunction

   assign out_valid = (count != '0);
   assign imem_req  = rst && !redirect_valid && has_credit(count, inflight);
   assign imem_addr = fetch_pc;
   assign push      = inflight && !redirect_valid;
   assign pop       = out_valid && out_ready && !redirect_valid;
   assign out_pc    = out_valid ? pc_mem[rd_ptr]    : hold_pc;
   assign out_instr = out_valid ? instr_mem[rd_ptr] : hold_instr;

   // Stage p0: fetch address generation and request issue
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_PC;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= {redirect_pc[DWIDTH-1:2], 2'b00};
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            fetch_pc <= fetch_pc + PC_STEP;
         end
      end
   end

   // Stage p1: returning instruction captured into the FIFO
   always_ff @(posedge clk) begin
      if (imem_req) begin
         inflight_pc <= fetch_pc;
      end
      if (push) begin
         pc_mem[wr_ptr]    <= inflight_pc;
         instr_mem[wr_ptr] <= imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push && !pop) begin
            count <= count + CNT_ONE;
         end else if (pop && !push) begin
            count <= count - CNT_ONE;
         end
      end
   end

   // Stage p2: last presented head, shown while the FIFO is empty
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_pc    <= '0;
         hold_instr <= '0;
      end else if (out_valid) begin
         hold_pc    <= pc_mem[rd_ptr];
         hold_instr <= instr_mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle-by-cycle vector table plus hand-written
// sequences for first-valid latency and asynchronous mid-cycle reset.
module tb_fetch_queue;

   localparam logic [31:0] MEM_BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[$];

   fetch_queue #(.DWIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: word at address a is MEM_BASE + a.
   always @(posedge clk) imem_rdata <= MEM_BASE + imem_addr;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0d: got 0x%08h, want 0x%08h", nm, idx, act, exp);
      end
   endtask

   // ctl = {rst, out_ready, redirect_valid}; ex = {imem_req, out_valid}
   task automatic add(input logic [2:0] ctl, input logic [31:0] rpc, input logic [1:0] ex,
                      input logic [31:0] addr, input logic [31:0] pc);
      vec_t v;
      v.rst  = ctl[2];
      v.rdy  = ctl[1];
      v.rv   = ctl[0];
      v.rpc  = rpc;
      v.req  = ex[1];
      v.vld  = ex[0];
      v.addr = addr;
      v.pc   = pc;
      vecs.push_back(v);
   endtask

   initial begin
      int lat;

      // Reset held for two cycles
      add(3'b000, 'h0, 2'b00, 'h0, 'h0);
      add(3'b000, 'h0, 2'b00, 'h0, 'h0);
      // Steady streaming with out_ready high
      for (int k = 0; k < 8; k++)
         add(3'b110, 'h0, {1'b1, k >= 2}, 32'(4 * k), (k >= 2) ? 32'(4 * (k - 2)) : 32'h0);
      // Reset, then stall for 10 cycles
      add(3'b000, 'h0, 2'b00, 'h0, 'h0);
      add(3'b100, 'h0, 2'b10, 'h0, 'h0);
      add(3'b100, 'h0, 2'b10, 'h4, 'h0);
      add(3'b100, 'h0, 2'b11, 'h8, 'h0);
      add(3'b100, 'h0, 2'b11, 'hC, 'h0);
      for (int k = 0; k < 6; k++)
         add(3'b100, 'h0, 2'b01, 'h10, 'h0);
      // Release: drain 0..0x10 with no gap
      add(3'b110, 'h0, 2'b01, 'h10, 'h0);
      add(3'b110, 'h0, 2'b11, 'h10, 'h4);
      add(3'b110, 'h0, 2'b11, 'h14, 'h8);
      add(3'b110, 'h0, 2'b11, 'h18, 'hC);
      add(3'b110, 'h0, 2'b11, 'h1C, 'h10);
      add(3'b100, 'h0, 2'b11, 'h20, 'h14);
      // Reset with three entries buffered, then restart at RESET_PC
      add(3'b000, 'h0, 2'b00, 'h0, 'h0);
      add(3'b110, 'h0, 2'b10, 'h0, 'h0);
      add(3'b110, 'h0, 2'b10, 'h4, 'h0);
      add(3'b110, 'h0, 2'b11, 'h8, 'h0);
      // Fill, redirect to 0x100 while full, then to misaligned 0x203
      add(3'b000, 'h0, 2'b00, 'h0, 'h0);
      add(3'b100, 'h0, 2'b10, 'h0, 'h0);
      add(3'b100, 'h0, 2'b10, 'h4, 'h0);
      add(3'b100, 'h0, 2'b11, 'h8, 'h0);
      add(3'b100, 'h0, 2'b11, 'hC, 'h0);
      add(3'b101, 'h100, 2'b01, 'h10, 'h0);
      add(3'b100, 'h0, 2'b10, 'h100, 'h0);
      add(3'b100, 'h0, 2'b10, 'h104, 'h0);
      add(3'b100, 'h0, 2'b11, 'h108, 'h100);
      add(3'b101, 'h203, 2'b01, 'h10C, 'h100);
      add(3'b100, 'h0, 2'b10, 'h200, 'h0);
      add(3'b100, 'h0, 2'b10, 'h204, 'h0);
      add(3'b100, 'h0, 2'b11, 'h208, 'h200);
      // Redirect together with a returning fetch and a pop
      add(3'b111, 'h300, 2'b01, 'h20C, 'h200);
      add(3'b110, 'h0, 2'b10, 'h300, 'h0);
      add(3'b110, 'h0, 2'b10, 'h304, 'h0);
      add(3'b110, 'h0, 2'b11, 'h308, 'h300);
      add(3'b110, 'h0, 2'b11, 'h30C, 'h304);
      // Back-to-back redirects: only 0x500 is fetched
      add(3'b111, 'h400, 2'b01, 'h310, 'h308);
      add(3'b111, 'h500, 2'b00, 'h400, 'h0);
      add(3'b110, 'h0, 2'b10, 'h500, 'h0);
      add(3'b110, 'h0, 2'b10, 'h504, 'h0);
      add(3'b110, 'h0, 2'b11, 'h508, 'h500);
      add(3'b110, 'h0, 2'b11, 'h50C, 'h504);

      #2 rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < vecs.size(); i++) begin
         rst            = vecs[i].rst;
         out_ready      = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         @(negedge clk);
         chk("imem_req",  i, 32'(imem_req),  32'(vecs[i].req));
         chk("imem_addr", i, imem_addr,      vecs[i].addr);
         chk("out_valid", i, 32'(out_valid), 32'(vecs[i].vld));
         if (vecs[i].vld) begin
            chk("out_pc",    i, out_pc,    vecs[i].pc);
            chk("out_instr", i, out_instr, MEM_BASE + vecs[i].pc);
         end else if (!vecs[i].rst) begin
            chk("out_pc_rst",    i, out_pc,    32'h0);
            chk("out_instr_rst", i, out_instr, 32'h0);
         end
         @(posedge clk); #1;
      end

      // First out_valid after reset release, bounded wait
      rst            = 1'b0;
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      lat = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = c;
            break;
         end
         @(posedge clk); #1;
      end
      chk("first_valid_cycle", 1000, 32'(lat), 32'd2);
      chk("first_valid_pc",    1000, out_pc,    32'h0);
      chk("first_valid_instr", 1000, out_instr, MEM_BASE);

      // Asynchronous reset asserted mid-cycle while streaming
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("pre_rst_valid", 1001, 32'(out_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_valid", 1001, 32'(out_valid), 32'd0);
      chk("async_rst_req",   1001, 32'(imem_req),  32'd0);
      chk("async_rst_addr",  1001, imem_addr,      32'h0);
      chk("async_rst_pc",    1001, out_pc,         32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("restart_req",  1002, 32'(imem_req), 32'd1);
      chk("restart_addr", 1002, imem_addr,     32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
